// File: rtl/unidad_control_pkg.sv
// Shared opcode classes and sequencer states for the microcontroller control unit.
package unidad_control_pkg;

    // Opcode classes on opcode[3:0]; any code with bit 3 set is an ALU operation.
    localparam logic [3:0] OPC_ALU  = 4'b1000;
    localparam logic [3:0] OPC_LDI  = 4'b0000;
    localparam logic [3:0] OPC_J    = 4'b0001;
    localparam logic [3:0] OPC_JZ   = 4'b0010;
    localparam logic [3:0] OPC_JNZ  = 4'b0011;
    localparam logic [3:0] OPC_NOP  = 4'b0100;
    localparam logic [3:0] OPC_HALT = 4'b0111;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_STEP = 2'd3
    } state_t;

endpackage

// File: rtl/unidad_control_decod.sv
// Purely combinational instruction decode; the caller decides whether it takes effect.
module uc_decod
    import unidad_control_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic       zero,
    output logic       s_inc,
    output logic       s_inm,
    output logic       we3,
    output logic [2:0] op,
    output logic       is_halt,
    output logic       is_illegal
);

    always_comb begin
        s_inc      = 1'b1;
        s_inm      = 1'b0;
        we3        = 1'b0;
        op         = 3'b000;
        is_halt    = 1'b0;
        is_illegal = 1'b0;
        if (opcode[3] == OPC_ALU[3]) begin
            op  = opcode[2:0];
            we3 = 1'b1;
        end else begin
            case (opcode)
                OPC_LDI: begin
                    s_inm = 1'b1;
                    we3   = 1'b1;
                end
                OPC_J:    s_inc = 1'b0;
                OPC_JZ:   s_inc = ~zero;
                OPC_JNZ:  s_inc = zero;
                OPC_NOP:  s_inc = 1'b1;
                OPC_HALT: is_halt = 1'b1;
                // Only 0101 and 0110 remain: executed as NOP but flagged.
                default:  is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/unidad_control.sv
// Control unit: run/halt/step sequencer wrapped around the opcode decode, with
// retired-instruction counter and sticky illegal-opcode flag.
module unidad_control
    import unidad_control_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             run,
    input  logic             step,
    input  logic             brk,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic [2:0]       op,
    output logic             pc_en,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] icount
);

    state_t           state_reg, state_next;
    logic             halted_reg, illegal_reg;
    logic [CNT_W-1:0] icount_reg;
    logic             executing;

    logic       dec_s_inc, dec_s_inm, dec_we3, dec_is_halt, dec_is_illegal;
    logic [2:0] dec_op;

    // opcode[5:4] overlap register/target fields and take no part in decode.
    logic unused_opcode_hi;
    assign unused_opcode_hi = ^opcode[5:4];

    uc_decod u_decod (
        .opcode     (opcode[3:0]),
        .zero       (zero),
        .s_inc      (dec_s_inc),
        .s_inm      (dec_s_inm),
        .we3        (dec_we3),
        .op         (dec_op),
        .is_halt    (dec_is_halt),
        .is_illegal (dec_is_illegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_BOOT;
            halted_reg  <= 1'b0;
            illegal_reg <= 1'b0;
            icount_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= (state_next == ST_HALT);
            if (executing && dec_is_illegal)
                illegal_reg <= 1'b1;
            if (executing)
                icount_reg <= icount_reg + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        executing  = 1'b0;
        case (state_reg)
            ST_BOOT: state_next = ST_RUN;
            ST_RUN: begin
                executing = 1'b1;
                // A HALT opcode still retires so resuming continues after it.
                if (dec_is_halt || brk)
                    state_next = ST_HALT;
            end
            ST_HALT: begin
                if (run)
                    state_next = ST_RUN;
                else if (step)
                    state_next = ST_STEP;
            end
            ST_STEP: begin
                executing  = 1'b1;
                state_next = ST_HALT;
            end
            default: state_next = ST_BOOT;
        endcase

        pc_en = executing;
        we3   = executing & dec_we3;
        s_inm = executing & dec_s_inm;
        s_inc = executing ? dec_s_inc : 1'b1;
        op    = executing ? dec_op : 3'b000;
    end

    assign halted  = halted_reg;
    assign illegal = illegal_reg;
    assign icount  = icount_reg;

endmodule

// File: tb/tb_unidad_control.sv
// Scoreboard bench for unidad_control: a stimulus process pushes expected
// outputs from a behavioural model, a monitor pops and compares each cycle.
module tb_unidad_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = '0;
    logic        zero = 1'b0, run = 1'b0, step = 1'b0, brk = 1'b0;
    logic        s_inc, s_inm, we3, pc_en, halted, illegal;
    logic [2:0]  op;
    logic [15:0] icount;

    int errors = 0;
    int checks = 0;

    unidad_control #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .run(run), .step(step), .brk(brk),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .op(op), .pc_en(pc_en),
        .halted(halted), .illegal(illegal), .icount(icount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic        s_inc, s_inm, we3, pc_en, halted, illegal;
        logic [2:0]  op;
        logic [15:0] icount;
    } exp_t;

    exp_t exp_q[$];

    // Behavioural model: booting for one cycle, otherwise either stopped or
    // executing; a granted single step executes one instruction then stops.
    bit          m_boot, m_stopped, m_single, m_illegal, pending;
    logic [15:0] m_retired;
    logic [5:0]  p_op;
    logic        p_run, p_step, p_brk;
    int          txn = 0;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s txn=%0d got=%0h expected=%0h", name, id, act, req);
        end
    endtask

    task automatic model_init();
        m_boot = 1; m_stopped = 0; m_single = 0; m_illegal = 0; m_retired = '0; pending = 0;
    endtask

    task automatic model_step();
        int code;
        code = int'(p_op[3:0]);
        if (m_boot) begin
            m_boot = 0;
        end else if (m_stopped) begin
            if (p_run) m_stopped = 0;
            else if (p_step) begin m_stopped = 0; m_single = 1; end
        end else begin
            m_retired = m_retired + 16'd1;
            if (code == 5 || code == 6) m_illegal = 1;
            if (m_single || code == 7 || p_brk) m_stopped = 1;
            m_single = 0;
        end
    endtask

    task automatic do_cycle(input logic [5:0] o, input logic z, input logic r, input logic s, input logic b);
        exp_t e;
        int code;
        @(posedge clk);
        if (pending) model_step();
        #1;
        reset = 1'b0;
        opcode = o; zero = z; run = r; step = s; brk = b;
        p_op = o; p_run = r; p_step = s; p_brk = b; pending = 1;
        code = int'(o[3:0]);
        e.id = txn++;
        e.s_inc = 1; e.s_inm = 0; e.we3 = 0; e.op = 3'b000; e.pc_en = 0;
        if (!m_boot && !m_stopped) begin
            e.pc_en = 1;
            if (code >= 8) begin e.op = o[2:0]; e.we3 = 1; end
            else if (code == 0) begin e.s_inm = 1; e.we3 = 1; end
            else if (code == 1) e.s_inc = 0;
            else if (code == 2) e.s_inc = !z;
            else if (code == 3) e.s_inc = z;
        end
        e.halted = m_stopped; e.illegal = m_illegal; e.icount = m_retired;
        exp_q.push_back(e);
        $display("txn %0d op=%b z=%b run=%b step=%b brk=%b exp pc_en=%b we3=%b icount=%0d",
                 e.id, o, z, r, s, b, e.pc_en, e.we3, e.icount);
    endtask

    // Reset asserted mid-cycle: outputs must drop without waiting for a clock edge.
    task automatic do_reset();
        @(posedge clk);
        if (pending) model_step();
        #2;
        reset = 1'b1;
        model_init();
        #1;
        chk("rst_illegal", txn, 32'(illegal), 32'd0);
        chk("rst_halted",  txn, 32'(halted),  32'd0);
        chk("rst_icount",  txn, 32'(icount),  32'd0);
        chk("rst_pc_en",   txn, 32'(pc_en),   32'd0);
        chk("rst_we3",     txn, 32'(we3),     32'd0);
        chk("rst_s_inc",   txn, 32'(s_inc),   32'd1);
        $display("reset asserted at txn %0d", txn);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("s_inc",   e.id, 32'(s_inc),   32'(e.s_inc));
                chk("s_inm",   e.id, 32'(s_inm),   32'(e.s_inm));
                chk("we3",     e.id, 32'(we3),     32'(e.we3));
                chk("op",      e.id, 32'(op),      32'(e.op));
                chk("pc_en",   e.id, 32'(pc_en),   32'(e.pc_en));
                chk("halted",  e.id, 32'(halted),  32'(e.halted));
                chk("illegal", e.id, 32'(illegal), 32'(e.illegal));
                chk("icount",  e.id, 32'(icount),  32'(e.icount));
            end
        end
    end

    initial begin : stimulus
        model_init();
        // Boot cycle, then first ALU instruction.
        do_cycle(6'b001010, 0, 0, 0, 0);
        do_cycle(6'b001010, 0, 0, 0, 0);
        // Conditional branches with both flag values.
        do_cycle(6'b000010, 1, 0, 0, 0);
        do_cycle(6'b000010, 0, 0, 0, 0);
        do_cycle(6'b000011, 1, 0, 0, 0);
        do_cycle(6'b000011, 0, 0, 0, 0);
        do_cycle(6'b110001, 0, 1, 1, 0);
        // HALT opcode, then five idle cycles.
        do_cycle(6'b000111, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) do_cycle(6'b001100, 0, 0, 0, 0);
        // Single step of an LDI.
        do_cycle(6'b000000, 0, 0, 1, 0);
        do_cycle(6'b000000, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) do_cycle(6'b000100, 0, 0, 0, 0);
        // run and step together: must free-run, not single-step.
        do_cycle(6'b000100, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) do_cycle(6'b101001, 1, 0, 0, 0);
        // brk completes the current instruction and stops.
        do_cycle(6'b100110, 0, 0, 0, 1);
        do_cycle(6'b000100, 0, 1, 0, 0);
        // Illegal opcode sets the sticky flag.
        do_cycle(6'b000101, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) do_cycle(6'b000100, 0, 0, 0, 0);
        do_reset();
        // Randomized traffic with occasional mid-run resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            else do_cycle(6'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 7) == 0));
        end
        @(negedge clk);
        #1;
        chk("queue_drained", txn, 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unidad_control.md
Name: unidad_control

Overview:
Control unit for the single-cycle microcontroller datapath, sitting directly downstream of that datapath's opcode/zero outputs and upstream of its select/write-enable inputs.
- Decodes each instruction in the same cycle it is fetched.
- Adds a run/halt/single-step sequencer, a retired-instruction counter and illegal-opcode capture.
- Drives a new pc_en into the datapath; its PC register gains a load enable.

Parameters:
CNT_W, 16, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  6  instruction bits [5:0] from datapath
zero  in  1  registered ALU zero flag from datapath
run  in  1  debug: leave HALT and free-run (level sampled per cycle)
step  in  1  debug: from HALT execute exactly one instruction
brk  in  1  debug: stop after current instruction
s_inc  out  1  1 = PC+1, 0 = jump target
s_inm  out  1  1 = write immediate, 0 = write ALU result
we3  out  1  register-file write enable
op  out  3  ALU operation
pc_en  out  1  PC load enable
halted  out  1  1 while in HALT
illegal  out  1  sticky: an undefined opcode was executed
icount  out  CNT_W  retired instruction count

Behaviour:
- Decode uses opcode[3:0] only; opcode[5:4] are ignored because they overlap register/target fields.
- Decode table, valid only when executing:
  - 1xxx ALU: op=opcode[2:0], we3=1, s_inm=0, s_inc=1.
  - 0000 LDI: s_inm=1, we3=1, s_inc=1, op=000.
  - 0001 J: s_inc=0, we3=0.
  - 0010 JZ: s_inc=~zero.
  - 0011 JNZ: s_inc=zero.
  - 0100 NOP: s_inc=1.
  - 0111 HALT: s_inc=1, we3=0.
  - 0101/0110 illegal: behave as NOP; set illegal.
- Default when not executing: we3=0, pc_en=0, s_inc=1, s_inm=0, op=000.
- States: BOOT, RUN, HALT, STEP. Reset enters BOOT.
- BOOT: not executing for exactly one cycle, so the fetch settles; next state is RUN.
- RUN: executing, pc_en=1.
  - HALT opcode: PC still advances past it, so a resume does not re-execute it; next state HALT.
  - brk=1: current instruction completes; next state HALT.
  - run/step: ignored.
- HALT: not executing; halted=1.
  - run=1: next RUN.
  - else step=1: next STEP.
  - run and step together: run wins.
- STEP: executing for one cycle; next state HALT, regardless of opcode, run or brk.
- icount: +1 on every cycle with pc_en=1, HALT opcode included; wraps modulo 2^CNT_W.
- illegal: set on the clock edge ending an executing cycle with an illegal opcode; cleared only by reset.
- halted, illegal and icount are registered. Decode outputs are combinational from state, opcode and zero (Mealy), giving zero-cycle latency to the datapath.
- Reset values:
  - Registered state: state=BOOT, halted=0, illegal=0, icount=0.
  - Combinational outputs take their not-executing defaults during BOOT: we3=0, pc_en=0, s_inc=1, s_inm=0, op=000.
- Reset mid-instruction: every output returns to its reset value asynchronously; no register write completes on the next edge because we3=0.
- JZ/JNZ test the flag registered from the most recent ALU instruction. LDI does not change zero (datapath property).

Decomposition:
- Shared package: opcode class constants (OPC_ALU, OPC_LDI, OPC_J, OPC_JZ, OPC_JNZ, OPC_NOP, OPC_HALT) and the state enum.
- Sub-module uc_decod: purely combinational opcode/zero decode producing s_inc, s_inm, we3, op, is_halt and is_illegal.
- unidad_control holds the FSM and counters, and gates the decode outputs with the executing condition.

Test Plan:
- Release reset with opcode=1010 → first cycle we3=0, pc_en=0 (BOOT); next cycle op=010, we3=1, pc_en=1, icount becomes 1.
- In RUN: opcode=0010 with zero=1 → s_inc=0; with zero=0 → s_inc=1; opcode=0011 inverts both results.
- opcode=0111 in RUN → pc_en=1 that cycle, then halted=1, pc_en=0, we3=0; icount unchanged while halted for 5 cycles.
- From HALT, pulse step for one cycle with opcode=0000 → one cycle we3=1, s_inm=1, then back to HALT; icount incremented by exactly 1.
- From HALT, assert run and step in the same cycle → RUN entered; the bench confirms state is RUN, not STEP.
- opcode=0101 in RUN → illegal=1 after the edge and stays 1 through 10 further cycles; asserting reset clears it asynchronously to 0.
